// File: rtl/accel_seq_if.sv
// Byte-transaction handshake between the accelerometer scheduler and the SPI engine.
// The scheduler is the master: it issues transactions, and the engine answers with done and read data.
interface accel_seq_if;
  logic       xfer_start;
  logic       xfer_rw;
  logic [7:0] xfer_addr;
  logic [7:0] xfer_wdata;
  logic       xfer_done;
  logic [7:0] xfer_rdata;

  modport master (
    output xfer_start, xfer_rw, xfer_addr, xfer_wdata,
    input  xfer_done, xfer_rdata
  );

  modport slave (
    input  xfer_start, xfer_rw, xfer_addr, xfer_wdata,
    output xfer_done, xfer_rdata
  );
endinterface

// File: rtl/accel_seq.sv
// ADXL362 transaction scheduler: configures POWER_CTL once, then reads the six X/Y/Z
// data bytes every sample period and publishes 12-bit axis words with a one-cycle strobe.
module accel_seq #(
  parameter int unsigned SAMPLE_DIV = 500000,
  parameter logic [7:0]  CTRL_VAL   = 8'h02,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               enable,
  input  logic               clr_status,
  accel_seq_if.master        xfer,
  output logic [11:0]        x_acc,
  output logic [11:0]        y_acc,
  output logic [11:0]        z_acc,
  output logic               sample_valid,
  output logic               init_done,
  output logic               busy,
  output logic               fault,
  output logic               overrun
);

  localparam logic [7:0] POWER_CTL = 8'h2D;
  localparam logic [7:0] XDATA_L   = 8'h0E;
  localparam int         TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [23:0]   TICK_LAST = 24'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    INIT_ISSUE, INIT_WAIT, IDLE, RD_ISSUE, RD_WAIT, PUBLISH, FAULT
  } state_t;

  state_t          state;
  logic [23:0]     tick_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [2:0]      idx;
  logic            pending;
  logic [7:0]      shadow [6];
  logic            tick;
  logic            tick_en;

  assign tick    = init_done && (tick_cnt == TICK_LAST);
  assign tick_en = tick && enable;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state           <= INIT_ISSUE;
      tick_cnt        <= '0;
      to_cnt          <= '0;
      idx             <= '0;
      pending         <= 1'b0;
      xfer.xfer_start <= 1'b0;
      xfer.xfer_rw    <= 1'b0;
      xfer.xfer_addr  <= '0;
      xfer.xfer_wdata <= '0;
      x_acc           <= '0;
      y_acc           <= '0;
      z_acc           <= '0;
      sample_valid    <= 1'b0;
      init_done       <= 1'b0;
      busy            <= 1'b0;
      fault           <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so every path below yields exactly one-cycle strobes.
      xfer.xfer_start <= 1'b0;
      sample_valid    <= 1'b0;

      // Clears come first so a same-cycle set further down takes priority.
      if (clr_status) begin
        fault   <= 1'b0;
        overrun <= 1'b0;
      end

      if (!init_done || tick) tick_cnt <= '0;
      else                    tick_cnt <= tick_cnt + 24'd1;

      // A tick in IDLE is consumed directly; elsewhere it is parked as a single pending request.
      if (tick_en) begin
        if (pending || state != IDLE) overrun <= 1'b1;
        if (state != IDLE)            pending <= 1'b1;
      end

      case (state)
        INIT_ISSUE: begin
          xfer.xfer_start <= 1'b1;
          xfer.xfer_rw    <= 1'b1;
          xfer.xfer_addr  <= POWER_CTL;
          xfer.xfer_wdata <= CTRL_VAL;
          busy            <= 1'b1;
          to_cnt          <= '0;
          state           <= INIT_WAIT;
        end
        INIT_WAIT, RD_WAIT: begin
          if (xfer.xfer_done) begin
            busy <= 1'b0;
            if (state == INIT_WAIT) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else if (idx == 3'd5) begin
              state <= PUBLISH;
            end else begin
              idx   <= idx + 3'd1;
              state <= RD_ISSUE;
            end
          end else if (to_cnt == TO_LAST) begin
            busy      <= 1'b0;
            fault     <= 1'b1;
            init_done <= 1'b0;
            state     <= FAULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (pending || tick_en) begin
            pending <= 1'b0;
            idx     <= '0;
            state   <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          xfer.xfer_start <= 1'b1;
          xfer.xfer_rw    <= 1'b0;
          xfer.xfer_addr  <= XDATA_L + 8'(idx);
          xfer.xfer_wdata <= 8'h00;
          busy            <= 1'b1;
          to_cnt          <= '0;
          state           <= RD_WAIT;
        end
        PUBLISH: begin
          x_acc        <= {shadow[1][3:0], shadow[0]};
          y_acc        <= {shadow[3][3:0], shadow[2]};
          z_acc        <= {shadow[5][3:0], shadow[4]};
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        FAULT:   state <= INIT_ISSUE;
        default: state <= INIT_ISSUE;
      endcase
    end
  end

  // NOTE: the shadow bytes carry no reset; each one is rewritten in the round before PUBLISH reads it.
  always_ff @(posedge clk_50) begin
    if (state == RD_WAIT && xfer.xfer_done) shadow[idx] <= xfer.xfer_rdata;
  end

endmodule
